lbd_addr_rcv: RTL and testbench

LBD_ADDR_RCV -- requirements
Module: lbd_addr_rcv

---
 rtl/lbd_addr_rcv_pkg.sv | 45 ++++
 rtl/lbd_addr_rcv_edge.sv | 35 +++
 rtl/lbd_addr_rcv.sv | 180 ++++++++++++++++++
 tb/tb_lbd_addr_rcv.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lbd_addr_rcv_pkg.sv
// -----------------------------------------------------------------------------
// lbd_addr_rcv_pkg
// Shared local-bus interface (BIF) definitions used by the address receiver:
//   - FSM state encoding (IDLE, DECODE, ROW, COL, ACK, PRECH)
//   - field extractors for the 24-bit local-bus address:
//       PPN [23:10], CA [9:0], bank [23:20], row [23:12], col [11:0]
// -----------------------------------------------------------------------------
package lbd_addr_rcv_pkg;

    // FSM state encoding, kept as plain constants for legacy tools
    typedef logic [2:0] lbdState_t;

    localparam lbdState_t ST_IDLE   = 3'd0;
    localparam lbdState_t ST_DECODE = 3'd1;
    localparam lbdState_t ST_ROW    = 3'd2;
    localparam lbdState_t ST_COL    = 3'd3;
    localparam lbdState_t ST_ACK    = 3'd4;
    localparam lbdState_t ST_PRECH  = 3'd5;

    // Physical page number
    function automatic logic [13:0] ppnOf(input logic [23:0] addr);
        return addr[23:10];
    endfunction

    // Column address within the page
    function automatic logic [9:0] caOf(input logic [23:0] addr);
        return addr[9:0];
    endfunction

    // Bank field compared against BASE
    function automatic logic [3:0] bankOf(input logic [23:0] addr);
        return addr[23:20];
    endfunction

    // Memory row address driven while RAS_n alone is low
    function automatic logic [11:0] rowOf(input logic [23:0] addr);
        return addr[23:12];
    endfunction

    // Memory column address driven while CAS_n is low
    function automatic logic [11:0] colOf(input logic [23:0] addr);
        return addr[11:0];
    endfunction

endpackage

// File: rtl/lbd_addr_rcv_edge.sv
// -----------------------------------------------------------------------------
// lbd_edge_det
// Registers a request line and produces a one-cycle rising-edge pulse.
// After reset the first sampled value only primes the register, so a line
// that is already high when reset releases is not reported as an edge.
// Ports:
//   sysclk     in  clock (rising edge)
//   sys_rst_n  in  synchronous active-low reset
//   din        in  request line (already synchronous to sysclk)
//   rise       out high on a cycle where din is 1 and its registered value is 0
// -----------------------------------------------------------------------------
module lbd_edge_det (
    input  logic sysclk,
    input  logic sys_rst_n,
    input  logic din,
    output logic rise
);

    logic din_r;
    logic primed_r;

    // Previous-cycle sample of din, plus a flag marking it as a real sample
    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            din_r    <= 1'b0;
            primed_r <= 1'b0;
        end else begin
            din_r    <= din;
            primed_r <= 1'b1;
        end
    end

    assign rise = primed_r & din & ~din_r;

endmodule

// File: rtl/lbd_addr_rcv.sv
// -----------------------------------------------------------------------------
// lbd_addr_rcv
// Local-bus address receiver: captures an address on a rising ECREQ with
// EADR_n low, checks its bank against BASE, and on a hit runs a RAS/CAS
// memory sequence followed by a bus acknowledge and a precharge gap.
// Parameters (legal 1..7): RAS_CYC, CAS_CYC, PRE_CYC.
// Ports:
//   sysclk, sys_rst_n          clock, synchronous active-low reset
//   LBD_23_0, ECREQ, EADR_n    bus address / request / address-valid (low)
//   BASE_3_0                   bank select compared with LBD[23:20]
//   ADR_Q, HIT                 captured address and bank-match flag
//   MA_11_0                    multiplexed row/column address
//   RAS_n, CAS_n, ACK_n        active-low strobes and acknowledge
//   BUSY                       high while the FSM is not idle
// All outputs are registered; strobes follow the state by one cycle, which
// gives a 2-cycle accept-to-RAS latency.
// -----------------------------------------------------------------------------
module lbd_addr_rcv
    import lbd_addr_rcv_pkg::*;
#(
    parameter int RAS_CYC = 2,
    parameter int CAS_CYC = 2,
    parameter int PRE_CYC = 1
) (
    input  logic        sysclk,
    input  logic        sys_rst_n,
    input  logic [23:0] LBD_23_0,
    input  logic        ECREQ,
    input  logic        EADR_n,
    input  logic [3:0]  BASE_3_0,
    output logic [23:0] ADR_Q,
    output logic        HIT,
    output logic [11:0] MA_11_0,
    output logic        RAS_n,
    output logic        CAS_n,
    output logic        ACK_n,
    output logic        BUSY
);

    localparam logic [2:0] RAS_LD = 3'(RAS_CYC - 1);
    localparam logic [2:0] CAS_LD = 3'(CAS_CYC - 1);
    localparam logic [2:0] PRE_LD = 3'(PRE_CYC - 1);

    lbdState_t   state_r;
    lbdState_t   nextState_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cntNext_s;
    logic        ecreqRise_s;
    logic        accept_s;
    logic        hitClr_s;
    logic        rasNext_s;
    logic        casNext_s;
    logic        ackNext_s;
    logic [11:0] maNext_s;

    lbd_edge_det u_edge (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .din       (ECREQ),
        .rise      (ecreqRise_s)
    );

    // Edges seen while busy are simply dropped: acceptance needs IDLE
    assign accept_s = (state_r == ST_IDLE) & ecreqRise_s & ~EADR_n;
    assign hitClr_s = (state_r == ST_PRECH) & (cnt_r == 3'd0);

    // Next state and shared phase counter (reloaded on entry to ROW/COL/PRECH)
    always_comb begin
        nextState_s = state_r;
        cntNext_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    nextState_s = ST_DECODE;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (HIT) begin
                    nextState_s = ST_ROW;
                    cntNext_s   = RAS_LD;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_ROW: begin
                if (cnt_r == 3'd0) begin
                    nextState_s = ST_COL;
                    cntNext_s   = CAS_LD;
                end else begin
                    cntNext_s   = cnt_r - 3'd1;
                end
            end
            ST_COL: begin
                if (cnt_r == 3'd0) begin
                    nextState_s = ST_ACK;
                end else begin
                    cntNext_s   = cnt_r - 3'd1;
                end
            end
            ST_ACK: begin
                if (!ECREQ) begin
                    nextState_s = ST_PRECH;
                    cntNext_s   = PRE_LD;
                end else begin
                    nextState_s = ST_ACK;
                end
            end
            ST_PRECH: begin
                if (cnt_r == 3'd0) begin
                    nextState_s = ST_IDLE;
                end else begin
                    cntNext_s   = cnt_r - 3'd1;
                end
            end
            default: begin
                nextState_s = ST_IDLE;
                cntNext_s   = 3'd0;
            end
        endcase
    end

    // Strobe and address values to present during the current state's next cycle
    always_comb begin
        rasNext_s = 1'b1;
        casNext_s = 1'b1;
        ackNext_s = 1'b1;
        maNext_s  = 12'h000;
        case (state_r)
            ST_ROW: begin
                rasNext_s = 1'b0;
                maNext_s  = rowOf(ADR_Q);
            end
            ST_COL: begin
                rasNext_s = 1'b0;
                casNext_s = 1'b0;
                maNext_s  = colOf(ADR_Q);
            end
            ST_ACK: begin
                ackNext_s = 1'b0;
            end
            default: begin
                maNext_s  = 12'h000;
            end
        endcase
    end

    // State, counter, address capture and registered outputs
    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            ADR_Q   <= 24'h000000;
            HIT     <= 1'b0;
            MA_11_0 <= 12'h000;
            RAS_n   <= 1'b1;
            CAS_n   <= 1'b1;
            ACK_n   <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            state_r <= nextState_s;
            cnt_r   <= cntNext_s;
            MA_11_0 <= maNext_s;
            RAS_n   <= rasNext_s;
            CAS_n   <= casNext_s;
            ACK_n   <= ackNext_s;
            BUSY    <= (nextState_s != ST_IDLE);
            if (accept_s) begin
                ADR_Q <= LBD_23_0;
                HIT   <= (bankOf(LBD_23_0) == BASE_3_0);
            end else if (hitClr_s) begin
                HIT   <= 1'b0;
            end else begin
                HIT   <= HIT;
            end
        end
    end

endmodule

// File: tb/tb_lbd_addr_rcv.sv
// -----------------------------------------------------------------------------
// tb_lbd_addr_rcv
// Two instances share one stimulus stream: A uses the default timing
// (2/2/1) and B the short-strobe, long-precharge set (1/1/3). A transaction
// model predicts each instance's outputs from accept/exit cycle numbers.
// -----------------------------------------------------------------------------
module tb_lbd_addr_rcv;

    logic        sysclk = 1'b0;
    logic        sys_rst_n;
    logic        ECREQ;
    logic        EADR_n;
    logic [23:0] LBD_23_0;
    logic [3:0]  BASE_3_0;

    logic [1:0][23:0] adrQ;
    logic [1:0][11:0] ma;
    logic [1:0]       hit, rasN, casN, ackN, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state, one slot per instance
    int          rCyc [2] = '{2, 1};
    int          cCyc [2] = '{2, 1};
    int          pCyc [2] = '{1, 3};
    string       nm   [2] = '{"A", "B"};
    logic        active [2];
    logic        hitM   [2];
    logic [23:0] adrM   [2];
    int          aCyc   [2];
    int          exitCyc[2];
    int          endCyc [2];
    int          ackExp [2];
    int          ackSeen[2];
    logic        ackPrev[2];
    logic        prevE;
    logic        eRnd;

    always #5 sysclk = ~sysclk;

    lbd_addr_rcv #(.RAS_CYC(2), .CAS_CYC(2), .PRE_CYC(1)) dutA (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n), .LBD_23_0(LBD_23_0),
        .ECREQ(ECREQ), .EADR_n(EADR_n), .BASE_3_0(BASE_3_0),
        .ADR_Q(adrQ[0]), .HIT(hit[0]), .MA_11_0(ma[0]),
        .RAS_n(rasN[0]), .CAS_n(casN[0]), .ACK_n(ackN[0]), .BUSY(busy[0])
    );

    lbd_addr_rcv #(.RAS_CYC(1), .CAS_CYC(1), .PRE_CYC(3)) dutB (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n), .LBD_23_0(LBD_23_0),
        .ECREQ(ECREQ), .EADR_n(EADR_n), .BASE_3_0(BASE_3_0),
        .ADR_Q(adrQ[1]), .HIT(hit[1]), .MA_11_0(ma[1]),
        .RAS_n(rasN[1]), .CAS_n(casN[1]), .ACK_n(ackN[1]), .BUSY(busy[1])
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Transaction-level model: tracks accept cycle, ACK exit cycle and idle cycle
    task automatic modelStep();
        logic riseM;
        cyc++;
        if (!sys_rst_n) begin
            prevE = 1'b1;   // a line high at release must first be seen low
            for (int i = 0; i < 2; i++) begin
                active[i] = 1'b0;
                hitM[i]   = 1'b0;
                adrM[i]   = 24'h000000;
            end
        end else begin
            riseM = ECREQ && !prevE;
            prevE = ECREQ;
            for (int i = 0; i < 2; i++) begin
                if (!active[i]) begin
                    if (riseM && !EADR_n) begin
                        active[i]  = 1'b1;
                        aCyc[i]    = cyc;
                        adrM[i]    = LBD_23_0;
                        hitM[i]    = (LBD_23_0[23:20] == BASE_3_0);
                        exitCyc[i] = -1;
                        endCyc[i]  = hitM[i] ? -1 : cyc + 1;
                    end
                end else if (hitM[i] && exitCyc[i] < 0 &&
                             cyc >= aCyc[i] + 2 + rCyc[i] + cCyc[i] && !ECREQ) begin
                    exitCyc[i] = cyc;
                    endCyc[i]  = cyc + pCyc[i];
                end
                if (active[i] && cyc == endCyc[i]) begin
                    active[i] = 1'b0;
                    hitM[i]   = 1'b0;
                end
            end
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < 2; i++) begin
            int t0, tc, ta;
            logic sq, eRas, eCas, eAck;
            logic [11:0] eMa;
            t0 = aCyc[i] + 2;
            tc = t0 + rCyc[i];
            ta = tc + cCyc[i];
            sq = active[i] && hitM[i];
            eRas = !(sq && cyc >= t0 && cyc < ta);
            eCas = !(sq && cyc >= tc && cyc < ta);
            eAck = !(sq && cyc >= ta && (exitCyc[i] < 0 || cyc <= exitCyc[i]));
            if (sq && cyc >= t0 && cyc < tc)      eMa = adrM[i][23:12];
            else if (sq && cyc >= tc && cyc < ta) eMa = adrM[i][11:0];
            else                                  eMa = 12'h000;
            if (sq && cyc == ta) ackExp[i]++;
            if (ackPrev[i] && !ackN[i]) ackSeen[i]++;
            ackPrev[i] = ackN[i];
            checkVal({nm[i], ".ADR_Q"}, 32'(adrQ[i]), 32'(adrM[i]));
            checkVal({nm[i], ".HIT"},   32'(hit[i]),  32'(hitM[i]));
            checkVal({nm[i], ".MA"},    32'(ma[i]),   32'(eMa));
            checkVal({nm[i], ".RAS_n"}, 32'(rasN[i]), 32'(eRas));
            checkVal({nm[i], ".CAS_n"}, 32'(casN[i]), 32'(eCas));
            checkVal({nm[i], ".ACK_n"}, 32'(ackN[i]), 32'(eAck));
            checkVal({nm[i], ".BUSY"},  32'(busy[i]), 32'(active[i]));
        end
    endtask

    // Drive inputs (just after a falling edge), clock once, check on the next falling edge
    task automatic step(input logic r, input logic e, input logic ea,
                        input logic [23:0] d, input logic [3:0] b);
        sys_rst_n = r;
        ECREQ     = e;
        EADR_n    = ea;
        LBD_23_0  = d;
        BASE_3_0  = b;
        @(posedge sysclk);
        modelStep();
        @(negedge sysclk);
        compareAll();
    endtask

    initial begin
        prevE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0; hitM[i] = 1'b0; adrM[i] = 24'h000000;
            aCyc[i] = -100; exitCyc[i] = -1; endCyc[i] = -1;
            ackExp[i] = 0; ackSeen[i] = 0; ackPrev[i] = 1'b1;
        end

        // reset, then ECREQ already high at release must not be accepted
        step(1'b0, 1'b0, 1'b0, 24'h000000, 4'h0);
        step(1'b0, 1'b1, 1'b0, 24'h3A5C21, 4'h3);
        repeat (4) step(1'b1, 1'b1, 1'b0, 24'h3A5C21, 4'h3);
        checkVal("postRst.BUSY", 32'(busy), 32'd0);
        step(1'b1, 1'b0, 1'b0, 24'h3A5C21, 4'h3);

        // hit: row 3A5 then column C21, ACK held while ECREQ stays high
        step(1'b1, 1'b1, 1'b0, 24'h3A5C21, 4'h3);
        checkVal("hit.ADR_Q", 32'(adrQ[0]), 32'h003A5C21);
        checkVal("hit.HIT", 32'(hit[0]), 32'd1);
        step(1'b1, 1'b1, 1'b0, 24'h000000, 4'h3);
        step(1'b1, 1'b1, 1'b0, 24'h000000, 4'h3);
        checkVal("hit.MA_row", 32'(ma[0]), 32'h3A5);
        checkVal("hit.RAS_row", 32'(rasN[0]), 32'd0);
        step(1'b1, 1'b1, 1'b0, 24'h000000, 4'h3);
        step(1'b1, 1'b1, 1'b0, 24'h000000, 4'h3);
        checkVal("hit.MA_col", 32'(ma[0]), 32'hC21);
        checkVal("hit.CAS_col", 32'(casN[0]), 32'd0);
        step(1'b1, 1'b1, 1'b0, 24'h000000, 4'h3);
        step(1'b1, 1'b1, 1'b0, 24'h000000, 4'h3);
        checkVal("hit.ACK", 32'(ackN[0]), 32'd0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 24'h000000, 4'h3);
        repeat (6) step(1'b1, 1'b0, 1'b0, 24'h000000, 4'h3);

        // miss: one cycle of BUSY, no strobes
        step(1'b1, 1'b1, 1'b0, 24'h7FFFFF, 4'h3);
        checkVal("miss.BUSY", 32'(busy[0]), 32'd1);
        checkVal("miss.HIT", 32'(hit[0]), 32'd0);
        step(1'b1, 1'b1, 1'b0, 24'h7FFFFF, 4'h3);
        checkVal("miss.BUSYoff", 32'(busy[0]), 32'd0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 24'h000000, 4'h3);

        // EADR_n high during the rise: no capture
        step(1'b1, 1'b1, 1'b1, 24'h3ABCDE, 4'h3);
        checkVal("eadr.ADR_Q", 32'(adrQ[0]), 32'h007FFFFF);
        checkVal("eadr.BUSY", 32'(busy[0]), 32'd0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 24'h000000, 4'h3);

        // ECREQ drops early and re-rises during COL: one short ACK, re-rise ignored
        step(1'b1, 1'b1, 1'b0, 24'h312345, 4'h3);
        step(1'b1, 1'b0, 1'b0, 24'h000000, 4'h3);
        step(1'b1, 1'b0, 1'b0, 24'h000000, 4'h3);
        step(1'b1, 1'b0, 1'b0, 24'h000000, 4'h3);
        step(1'b1, 1'b1, 1'b0, 24'h399999, 4'h3);
        repeat (3) step(1'b1, 1'b1, 1'b0, 24'h000000, 4'h3);
        repeat (6) step(1'b1, 1'b0, 1'b0, 24'h000000, 4'h3);

        // reset pulled in COL, ECREQ held high after release
        step(1'b1, 1'b1, 1'b0, 24'h3F0F0F, 4'h3);
        repeat (3) step(1'b1, 1'b1, 1'b0, 24'h000000, 4'h3);
        step(1'b0, 1'b1, 1'b0, 24'h000000, 4'h3);
        checkVal("rstCol.RAS_n", 32'(rasN), 32'd3);
        checkVal("rstCol.CAS_n", 32'(casN), 32'd3);
        checkVal("rstCol.BUSY", 32'(busy), 32'd0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 24'h3F0F0F, 4'h3);
        checkVal("rstCol.noAccept", 32'(busy), 32'd0);
        step(1'b1, 1'b0, 1'b0, 24'h000000, 4'h3);

        // randomized traffic with biased bank matches and rare resets
        eRnd = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            logic [3:0]  b;
            logic [23:0] d;
            logic        r;
            if ($urandom_range(0, 7) == 0) eRnd = ~eRnd;
            b = 4'($urandom_range(0, 3));
            d = 24'($urandom);
            if ($urandom_range(0, 1) == 1) d[23:20] = b;
            r = ($urandom_range(0, 299) != 0);
            step(r, eRnd, ($urandom_range(0, 7) == 0), d, b);
        end
        repeat (12) step(1'b1, 1'b0, 1'b0, 24'h000000, 4'h0);

        checkVal("A.ackCount", 32'(ackSeen[0]), 32'(ackExp[0]));
        checkVal("B.ackCount", 32'(ackSeen[1]), 32'(ackExp[1]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
